// File: rtl/fetch_stage.sv
// Instruction fetch with PC ownership, next-PC select, single-outstanding imem handshake and IF/ID register.
// Latency: a word acked in cycle t appears on ID_* in cycle t+1; one instruction per cycle on zero-wait memory.
// Backpressure: IF_ID_write parks an acked word in a one-entry skid buffer; no new request is issued until it drains.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        IF_ID_write,
  input  logic        IF_ID_flush,
  input  logic [1:0]  s_npc,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ID_pc,
  output logic [31:0] ID_pc4,
  output logic [31:0] ID_instr,
  output logic        ID_valid
);

  // REQ: request for pc outstanding; HOLD: word parked in skid; KILL: stale request in flight.
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    HOLD = 2'd1,
    KILL = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] skid_dat;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        word_vld;
  logic [31:0] word_dat;
  logic        word_load;

  assign pc_plus4 = pc + 32'd4;

  // Next-PC select: only branch/jump redirect; 11 falls back to sequential; frozen PC ignores redirects.
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = jump_target;
    case (s_npc)
      2'b01: begin
        redirect    = ~pc_write;
        redirect_pc = branch_target;
      end
      2'b10: begin
        redirect    = ~pc_write;
        redirect_pc = jump_target;
      end
      default: begin
        redirect    = 1'b0;
        redirect_pc = jump_target;
      end
    endcase
  end

  // A word for the current PC is either arriving now or already parked in the skid buffer.
  always_comb begin
    word_vld  = ((state == REQ) && imem_ack) || (state == HOLD);
    word_dat  = (state == HOLD) ? skid_dat : imem_rdata;
    // The word is consumed only when IF/ID actually takes it; a redirect discards it.
    word_load = word_vld && !redirect && !IF_ID_flush && !IF_ID_write;
  end

  // Request is gated by rst so the memory never sees a request while held in reset.
  assign imem_req  = (state == REQ) && !rst;
  assign imem_addr = pc;

  // Fetch FSM, PC and skid buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= REQ;
      pc       <= RESET_PC;
      skid_dat <= NOP_INSTR;
    end else if (redirect) begin
      pc <= redirect_pc;
      case (state)
        // A request still in flight must have its ack swallowed before refetching.
        // Once the stale ack lands, nothing is outstanding, so REQ is safe even mid-redirect.
        REQ, KILL: state <= imem_ack ? REQ : KILL;
        default:   state <= REQ;
      endcase
    end else begin
      if (word_load && !pc_write) begin
        pc <= pc_plus4;
      end
      case (state)
        REQ: begin
          // Acked but not taken by IF/ID (hold or flush): park it instead of refetching.
          if (imem_ack && !word_load) begin
            skid_dat <= imem_rdata;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (word_load) begin
            state <= REQ;
          end
        end
        KILL: begin
          if (imem_ack) begin
            state <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

  // IF/ID register: reset > flush bubble > hold > load word > bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ID_pc    <= 32'h0000_0000;
      ID_pc4   <= 32'h0000_0000;
      ID_instr <= NOP_INSTR;
      ID_valid <= 1'b0;
    end else if (IF_ID_flush) begin
      ID_instr <= NOP_INSTR;
      ID_valid <= 1'b0;
    end else if (IF_ID_write) begin
      ID_valid <= ID_valid;
    end else if (word_load) begin
      ID_pc    <= pc;
      ID_pc4   <= pc_plus4;
      ID_instr <= word_dat;
      ID_valid <= 1'b1;
    end else begin
      ID_instr <= NOP_INSTR;
      ID_valid <= 1'b0;
    end
  end

endmodule
